ethmac_wb_timeout: RTL and testbench

//  Registered Wishbone slice with bus-timeout protection. Sits between the Ethernet MAC

---
 rtl/ethmac_wb_timeout.sv | 134 +++++++++++++
 tb/tb_ethmac_wb_timeout.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethmac_wb_timeout.sv
// ethmac_wb_timeout: registered Wishbone slice between the Ethernet DMA and the system arbiter.
// Aborts a stalled request with err after TIMEOUT cycles and counts the aborts (rev 1.0).
`default_nettype none

module ethmac_wb_timeout #(
   parameter int WB_DWIDTH = 32,
   parameter int WB_SWIDTH = 4,
   parameter int TIMEOUT   = 255,
   parameter int TW_WIDTH  = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [31:0]          i_s_wb_adr,
   input  logic [WB_SWIDTH-1:0] i_s_wb_sel,
   input  logic                 i_s_wb_we,
   input  logic [WB_DWIDTH-1:0] i_s_wb_wdat,
   input  logic                 i_s_wb_cyc,
   input  logic                 i_s_wb_stb,
   output logic [WB_DWIDTH-1:0] o_s_wb_rdat,
   output logic                 o_s_wb_ack,
   output logic                 o_s_wb_err,
   output logic [31:0]          o_m_wb_adr,
   output logic [WB_SWIDTH-1:0] o_m_wb_sel,
   output logic                 o_m_wb_we,
   output logic [WB_DWIDTH-1:0] o_m_wb_wdat,
   output logic                 o_m_wb_cyc,
   output logic                 o_m_wb_stb,
   input  logic [WB_DWIDTH-1:0] i_m_wb_rdat,
   input  logic                 i_m_wb_ack,
   input  logic                 i_m_wb_err,
   output logic                 o_timeout,
   output logic [7:0]           o_timeout_cnt,
   input  logic                 i_clr_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [TW_WIDTH-1:0] TCNT_LAST = TW_WIDTH'(TIMEOUT - 1);

   state_t              state;
   logic [TW_WIDTH-1:0] tcnt;
   logic                timeout_hit;

   // Lowest-priority REQ exit: only fires when nothing else ended the request this cycle.
   assign timeout_hit = (state == REQ) && i_s_wb_cyc && !i_m_wb_err && !i_m_wb_ack
                        && (tcnt == TCNT_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= IDLE;
         tcnt          <= '0;
         o_s_wb_rdat   <= '0;
         o_s_wb_ack    <= 1'b0;
         o_s_wb_err    <= 1'b0;
         o_m_wb_adr    <= '0;
         o_m_wb_sel    <= '0;
         o_m_wb_we     <= 1'b0;
         o_m_wb_wdat   <= '0;
         o_m_wb_cyc    <= 1'b0;
         o_m_wb_stb    <= 1'b0;
         o_timeout     <= 1'b0;
         o_timeout_cnt <= '0;
      end else begin
         o_s_wb_ack <= 1'b0;
         o_s_wb_err <= 1'b0;
         o_timeout  <= 1'b0;

         case (state)
            IDLE: begin
               if (i_s_wb_cyc && i_s_wb_stb) begin
                  o_m_wb_adr  <= i_s_wb_adr;
                  o_m_wb_sel  <= i_s_wb_sel;
                  o_m_wb_we   <= i_s_wb_we;
                  o_m_wb_wdat <= i_s_wb_wdat;
                  o_m_wb_cyc  <= 1'b1;
                  o_m_wb_stb  <= 1'b1;
                  tcnt        <= '0;
                  state       <= REQ;
               end
            end
            REQ: begin
               if (!i_s_wb_cyc) begin
                  o_m_wb_cyc <= 1'b0;
                  o_m_wb_stb <= 1'b0;
                  state      <= IDLE;
               end else if (i_m_wb_err) begin
                  o_m_wb_cyc <= 1'b0;
                  o_m_wb_stb <= 1'b0;
                  o_s_wb_err <= 1'b1;
                  state      <= RESP;
               end else if (i_m_wb_ack) begin
                  // Read data is only meaningful for reads; writes leave it untouched.
                  if (!o_m_wb_we) begin
                     o_s_wb_rdat <= i_m_wb_rdat;
                  end
                  o_m_wb_cyc <= 1'b0;
                  o_m_wb_stb <= 1'b0;
                  o_s_wb_ack <= 1'b1;
                  state      <= RESP;
               end else if (timeout_hit) begin
                  o_m_wb_cyc <= 1'b0;
                  o_m_wb_stb <= 1'b0;
                  o_s_wb_err <= 1'b1;
                  o_timeout  <= 1'b1;
                  state      <= RESP;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               o_m_wb_cyc <= 1'b0;
               o_m_wb_stb <= 1'b0;
               state      <= IDLE;
            end
         endcase

         if (i_clr_cnt) begin
            o_timeout_cnt <= '0;
         end else if (timeout_hit && (o_timeout_cnt != 8'hFF)) begin
            o_timeout_cnt <= o_timeout_cnt + 8'd1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ethmac_wb_timeout.sv
// tb_ethmac_wb_timeout: directed self-checking bench for ethmac_wb_timeout (128-bit, TIMEOUT=255).
`default_nettype none

module tb_ethmac_wb_timeout;

   localparam int DW = 128;
   localparam int SW = 16;
   localparam int TO = 255;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   s_adr;
   logic [SW-1:0] s_sel;
   logic          s_we;
   logic [DW-1:0] s_wdat;
   logic          s_cyc, s_stb;
   logic [DW-1:0] s_rdat;
   logic          s_ack, s_err;
   logic [31:0]   m_adr;
   logic [SW-1:0] m_sel;
   logic          m_we;
   logic [DW-1:0] m_wdat;
   logic          m_cyc, m_stb;
   logic [DW-1:0] m_rdat;
   logic          m_ack, m_err;
   logic          timeout;
   logic [7:0]    tcnt;
   logic          clr;

   int errors = 0;
   int checks = 0;

   localparam logic [DW-1:0] RD1 = 128'hA5A5_0001_1234_5678_9ABC_DEF0_0F0F_1004;
   localparam logic [DW-1:0] RD2 = 128'h0BAD_CAFE_0000_0000_FFFF_FFFF_5555_AAAA;
   localparam logic [DW-1:0] WD  = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;

   ethmac_wb_timeout #(
      .WB_DWIDTH(DW), .WB_SWIDTH(SW), .TIMEOUT(TO), .TW_WIDTH(8)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_s_wb_adr(s_adr), .i_s_wb_sel(s_sel), .i_s_wb_we(s_we), .i_s_wb_wdat(s_wdat),
      .i_s_wb_cyc(s_cyc), .i_s_wb_stb(s_stb),
      .o_s_wb_rdat(s_rdat), .o_s_wb_ack(s_ack), .o_s_wb_err(s_err),
      .o_m_wb_adr(m_adr), .o_m_wb_sel(m_sel), .o_m_wb_we(m_we), .o_m_wb_wdat(m_wdat),
      .o_m_wb_cyc(m_cyc), .o_m_wb_stb(m_stb),
      .i_m_wb_rdat(m_rdat), .i_m_wb_ack(m_ack), .i_m_wb_err(m_err),
      .o_timeout(timeout), .o_timeout_cnt(tcnt), .i_clr_cnt(clr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a request while the DUT is idle; returns in the first downstream-strobe cycle.
   task automatic start_req(input logic [31:0] a, input logic [SW-1:0] s, input logic w,
                            input logic [DW-1:0] d);
      s_adr = a; s_sel = s; s_we = w; s_wdat = d; s_cyc = 1'b1; s_stb = 1'b1;
      tick();
   endtask

   task automatic end_req();
      s_cyc = 1'b0; s_stb = 1'b0;
   endtask

   // Runs one unanswered request; count is sampled once back in IDLE.
   task automatic run_timeout(input bit clr_last, output int n, output logic err,
                              output logic ack, output logic to, output logic [7:0] cnt);
      start_req(32'h0000_3000, '1, 1'b0, '0);
      n = 0;
      while (m_stb && n < 300) begin
         n++;
         if (clr_last && n == TO) clr = 1'b1;
         tick();
      end
      err = s_err; ack = s_ack; to = timeout;
      end_req();
      tick();
      clr = 1'b0;
      cnt = tcnt;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if ({m_cyc, m_stb, s_ack, s_err, timeout} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got cyc,stb,ack,err,to=%b required 00000",
                  {m_cyc, m_stb, s_ack, s_err, timeout});
      end
      checks++;
      if (tcnt !== 8'd0 || s_rdat !== '0 || m_adr !== 32'd0) begin
         errors++;
         $display("FAIL reset_data: got cnt=%0d rdat=%h adr=%h required all zero", tcnt, s_rdat, m_adr);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_read();
      start_req(32'h0000_1004, '1, 1'b0, '0);
      checks++;
      if (!(m_cyc === 1'b1 && m_stb === 1'b1 && m_adr === 32'h0000_1004 && m_we === 1'b0 && s_ack === 1'b0)) begin
         errors++;
         $display("FAIL read_req: got cyc=%b stb=%b adr=%h we=%b ack=%b required 1 1 00001004 0 0",
                  m_cyc, m_stb, m_adr, m_we, s_ack);
      end
      m_ack = 1'b1; m_rdat = RD1;
      tick();
      m_ack = 1'b0; m_rdat = '0;
      end_req();
      checks++;
      if (!(s_ack === 1'b1 && s_err === 1'b0 && s_rdat === RD1 && m_stb === 1'b0)) begin
         errors++;
         $display("FAIL read_ack: got ack=%b err=%b rdat=%h stb=%b required 1 0 %h 0",
                  s_ack, s_err, s_rdat, m_stb, RD1);
      end
      tick();
      checks++;
      if (s_ack !== 1'b0) begin
         errors++;
         $display("FAIL read_ack_pulse: got ack=%b required 0", s_ack);
      end
   endtask

   task automatic test_write();
      int bad = 0;
      int acks = 0;
      start_req(32'h0000_2000, 16'h00F0, 1'b1, WD);
      s_wdat = ~WD; s_sel = 16'hFFFF; s_adr = 32'hFFFF_FFFF;
      for (int i = 1; i <= 5; i++) begin
         if (!(m_stb === 1'b1 && m_wdat === WD && m_sel === 16'h00F0 && m_we === 1'b1 &&
               m_adr === 32'h0000_2000 && s_ack === 1'b0)) bad++;
         if (i == 5) begin
            m_ack = 1'b1; m_rdat = RD2;
         end
         tick();
      end
      m_ack = 1'b0;
      end_req();
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL write_stable: got %0d unstable cycles required 0", bad);
      end
      for (int i = 0; i < 4; i++) begin
         if (s_ack === 1'b1) acks++;
         tick();
      end
      checks++;
      if (acks != 1) begin
         errors++;
         $display("FAIL write_single_ack: got %0d acks required 1", acks);
      end
      checks++;
      if (s_rdat !== RD1) begin
         errors++;
         $display("FAIL write_rdat_hold: got %h required %h", s_rdat, RD1);
      end
   endtask

   task automatic test_timeout();
      int n; logic err, ack, to; logic [7:0] cnt;
      run_timeout(1'b0, n, err, ack, to, cnt);
      checks++;
      if (n != TO) begin
         errors++;
         $display("FAIL timeout_len: got stb high %0d cycles required %0d", n, TO);
      end
      checks++;
      if (!(err === 1'b1 && ack === 1'b0 && to === 1'b1 && cnt === 8'd1)) begin
         errors++;
         $display("FAIL timeout_resp: got err=%b ack=%b to=%b cnt=%0d required 1 0 1 1", err, ack, to, cnt);
      end
      checks++;
      if (timeout !== 1'b0 || s_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pulse: got to=%b err=%b required 0 0", timeout, s_err);
      end
   endtask

   task automatic test_err_abort();
      int resp = 0;
      start_req(32'h0000_4000, '1, 1'b0, '0);
      tick();
      m_ack = 1'b1; m_err = 1'b1; m_rdat = RD2;
      tick();
      m_ack = 1'b0; m_err = 1'b0;
      end_req();
      checks++;
      if (!(s_err === 1'b1 && s_ack === 1'b0 && s_rdat === RD1 && tcnt === 8'd1 && timeout === 1'b0)) begin
         errors++;
         $display("FAIL err_priority: got err=%b ack=%b rdat=%h cnt=%0d to=%b required 1 0 %h 1 0",
                  s_err, s_ack, s_rdat, tcnt, timeout, RD1);
      end
      tick();
      start_req(32'h0000_5000, '1, 1'b0, '0);
      end_req();
      tick();
      checks++;
      if (m_cyc !== 1'b0 || m_stb !== 1'b0) begin
         errors++;
         $display("FAIL abort_drop: got cyc=%b stb=%b required 0 0", m_cyc, m_stb);
      end
      m_ack = 1'b1; m_err = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (s_ack === 1'b1 || s_err === 1'b1 || m_stb === 1'b1) resp++;
         tick();
      end
      m_ack = 1'b0; m_err = 1'b0;
      checks++;
      if (resp != 0) begin
         errors++;
         $display("FAIL abort_no_resp: got %0d response cycles required 0", resp);
      end
   endtask

   task automatic test_reset_mid();
      int resp = 0;
      start_req(32'h0000_6000, '1, 1'b0, '0);
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      end_req();
      checks++;
      if ({m_cyc, m_stb, s_ack, s_err} !== 4'b0 || tcnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid: got cyc,stb,ack,err=%b cnt=%0d required 0000 0",
                  {m_cyc, m_stb, s_ack, s_err}, tcnt);
      end
      for (int i = 0; i < 3; i++) begin
         if (s_ack === 1'b1 || s_err === 1'b1 || m_cyc === 1'b1) resp++;
         tick();
      end
      checks++;
      if (resp != 0) begin
         errors++;
         $display("FAIL reset_mid_quiet: got %0d active cycles required 0", resp);
      end
      start_req(32'h0000_7008, '1, 1'b0, '0);
      m_ack = 1'b1; m_rdat = RD2;
      tick();
      m_ack = 1'b0;
      end_req();
      checks++;
      if (!(s_ack === 1'b1 && s_rdat === RD2)) begin
         errors++;
         $display("FAIL reset_mid_next: got ack=%b rdat=%h required 1 %h", s_ack, s_rdat, RD2);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int acks = 0;
      int stbs = 0;
      int overlap = 0;
      s_adr = 32'h0000_8000; s_sel = '1; s_we = 1'b0; s_cyc = 1'b1; s_stb = 1'b1;
      m_ack = 1'b1; m_rdat = RD1;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (s_ack === 1'b1) acks++;
         if (m_stb === 1'b1) stbs++;
         if (s_ack === 1'b1 && m_stb === 1'b1) overlap++;
      end
      end_req();
      m_ack = 1'b0;
      tick();
      checks++;
      if (!(acks == 3 && stbs == 3 && overlap == 0)) begin
         errors++;
         $display("FAIL back_to_back: got acks=%0d stbs=%0d overlap=%0d required 3 3 0", acks, stbs, overlap);
      end
   endtask

   task automatic test_saturate();
      int n; logic err, ack, to; logic [7:0] cnt;
      int badlen = 0;
      for (int i = 0; i < 256; i++) begin
         run_timeout(1'b0, n, err, ack, to, cnt);
         if (n != TO || err !== 1'b1 || to !== 1'b1) badlen++;
      end
      checks++;
      if (cnt !== 8'd255 || badlen != 0) begin
         errors++;
         $display("FAIL saturate: got cnt=%0d bad_runs=%0d required 255 0", cnt, badlen);
      end
      run_timeout(1'b1, n, err, ack, to, cnt);
      checks++;
      if (cnt !== 8'd0 || to !== 1'b1 || err !== 1'b1) begin
         errors++;
         $display("FAIL clr_wins: got cnt=%0d to=%b err=%b required 0 1 1", cnt, to, err);
      end
   endtask

   initial begin
      rst = 1'b1; s_adr = '0; s_sel = '0; s_we = 1'b0; s_wdat = '0; s_cyc = 1'b0; s_stb = 1'b0;
      m_rdat = '0; m_ack = 1'b0; m_err = 1'b0; clr = 1'b0;
      test_reset();
      test_read();
      test_write();
      test_timeout();
      test_err_abort();
      test_reset_mid();
      test_back_to_back();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
